uart_hex_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 104 ++++++++++
 rtl/uart_hex_tx.sv | 102 ++++++++++
 tb/tb_uart_hex_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and helpers for the UART hex reporter.
package uart_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_M10 = 8'h37;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic int unsigned bit_cyc(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // 0..9 -> '0'..'9', 10..15 -> 'A'..'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? ASCII_0 + {4'd0, v} : ASCII_A_M10 + {4'd0, v};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready input; ready also rises in the last
// stop-bit cycle so back-to-back bytes leave with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       txd
);

  localparam int unsigned CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             bit_end;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case leaves one unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    txd_d    = txd_q;
    in_ready = 1'b0;
    bit_end  = (cnt_q == CNT_LAST);

    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        cnt_d    = '0;
        if (in_valid) begin
          state_d = START;
          txd_d   = 1'b0;
          shreg_d = in_byte;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // Accepting here starts the next start bit on the very next cycle.
          in_ready = 1'b1;
          if (in_valid) begin
            state_d = START;
            txd_d   = 1'b0;
            shreg_d = in_byte;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
    end
    // NOTE: the shift register is pure datapath, always loaded before use, so it is deliberately not reset.
    shreg_q <= shreg_d;
  end

  assign txd = txd_q;

endmodule

// File: rtl/uart_hex_tx.sv
// Reports each 4-bit value update as an ASCII hex character (plus optional
// CR LF) on UART_TXD, with a one-deep pending buffer for updates while busy.
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter bit          SEND_CRLF = 1'b1
) (
  input  logic       FPGA_CLK,
  input  logic       RESET,
  input  logic [3:0] data,
  input  logic       data_valid,
  output logic       busy,
  output logic       dropped,
  output logic       UART_TXD
);

  localparam int unsigned BIT_CYC = bit_cyc(CLK_HZ, BAUD);

  logic       active_q, active_d;
  logic       more_q, more_d;
  logic [1:0] idx_q, idx_d;
  logic       pend_q, pend_d;
  logic [3:0] pend_data_q, pend_data_d;
  logic       dropped_q, dropped_d;

  logic       tx_valid, tx_ready;
  logic [7:0] tx_byte;
  logic [3:0] next_val;

  always_comb begin
    active_d    = active_q;
    more_d      = more_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    dropped_d   = data_valid & active_q & pend_q;
    tx_valid    = 1'b0;
    tx_byte     = (idx_q == 2'd1) ? ASCII_CR : ASCII_LF;
    next_val    = data_valid ? data : pend_data_q;

    if (data_valid && active_q) begin
      pend_d      = 1'b1;
      pend_data_d = data;
    end

    // A message starts either from idle or in the last stop cycle of the
    // previous message; the serializer is ready in both, so byte 0 is taken at once.
    if (!active_q || (!more_q && tx_ready)) begin
      if (data_valid || pend_q) begin
        tx_valid = 1'b1;
        tx_byte  = hex_ascii(next_val);
        active_d = 1'b1;
        more_d   = SEND_CRLF;
        idx_d    = 2'd1;
        pend_d   = 1'b0;
      end else begin
        active_d = 1'b0;
      end
    end else if (more_q) begin
      tx_valid = 1'b1;
      if (tx_ready) begin
        idx_d  = idx_q + 2'd1;
        more_d = (idx_q == 2'd1);
      end
    end
  end

  always_ff @(posedge FPGA_CLK) begin
    if (RESET) begin
      active_q    <= 1'b0;
      more_q      <= 1'b0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      dropped_q   <= 1'b0;
    end else begin
      active_q    <= active_d;
      more_q      <= more_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      dropped_q   <= dropped_d;
    end
  end

  uart_tx_byte #(
    .BIT_CYC (BIT_CYC)
  ) u_tx (
    .clk      (FPGA_CLK),
    .rst      (RESET),
    .in_byte  (tx_byte),
    .in_valid (tx_valid),
    .in_ready (tx_ready),
    .txd      (UART_TXD)
  );

  assign busy    = active_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: line monitors decode frames, a message-level model
// predicts bytes, start times, busy windows and drop pulses.
module tb_uart_hex_tx;

  localparam int BIT  = 50_000_000 / 115_200;
  localparam int LEN3 = 30 * BIT;
  localparam int LEN1 = 10 * BIT;

  typedef struct {int line; int val; int start; bit ok;} frame_t;
  typedef struct {int line; int rise; int fall;} epi_t;
  typedef struct {int n; int v;} stim_t;

  logic       clk = 1'b0;
  logic       rst0, rst1, dv0, dv1, busy0, busy1, drop0, drop1, txd0, txd1;
  logic [3:0] data0, data1;
  int         cyc = 0;
  int         checks = 0, errors = 0;

  frame_t act_f_q[$], exp_f_q[$], got_f[$];
  epi_t   act_e_q[$], exp_e_q[$], got_e[$];
  stim_t  stim0_q[$], stim1_q[$];
  int     drop_cnt[2];
  int     exp_drops;

  uart_hex_tx dut0 (
    .FPGA_CLK (clk), .RESET (rst0), .data (data0), .data_valid (dv0),
    .busy (busy0), .dropped (drop0), .UART_TXD (txd0)
  );

  uart_hex_tx #(.SEND_CRLF (1'b0)) dut1 (
    .FPGA_CLK (clk), .RESET (rst1), .data (data1), .data_valid (dv1),
    .busy (busy1), .dropped (drop1), .UART_TXD (txd1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic get_txd(int w);  return (w == 0) ? txd0  : txd1;  endfunction
  function automatic logic get_rst(int w);  return (w == 0) ? rst0  : rst1;  endfunction
  function automatic logic get_busy(int w); return (w == 0) ? busy0 : busy1; endfunction
  function automatic logic get_drop(int w); return (w == 0) ? drop0 : drop1; endfunction

  task automatic check(input string tag, input int obs, input int want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, want, want);
    end
  endtask

  // Samples every cycle of a 10-bit frame; aborts silently if reset hits mid-frame.
  task automatic capture_frame(input int w);
    logic [9:0] bits;
    bit ok;
    int t0;
    ok = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < BIT; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (get_rst(w) === 1'b1) return;
        if (c == 0) bits[k] = get_txd(w);
        else if (get_txd(w) !== bits[k]) ok = 1'b0;
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    act_f_q.push_back('{w, int'(bits[8:1]), t0, ok});
  endtask

  task automatic watch_line(input int w);
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (get_rst(w) === 1'b0 && prev === 1'b1 && get_txd(w) === 1'b0) capture_frame(w);
      prev = get_txd(w);
    end
  endtask

  task automatic watch_busy(input int w);
    logic prev;
    int   rise;
    prev = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (get_busy(w) === 1'b1 && prev === 1'b0) rise = cyc;
      if (get_busy(w) === 1'b0 && prev === 1'b1) act_e_q.push_back('{w, rise, cyc});
      if (get_drop(w) === 1'b1) drop_cnt[w]++;
      prev = get_busy(w);
    end
  endtask

  initial watch_line(0);
  initial watch_line(1);
  initial watch_busy(0);
  initial watch_busy(1);

  function automatic void push_msg(int v, int start, bit crlf);
    string hex;
    hex = "0123456789ABCDEF";
    exp_f_q.push_back('{0, int'(hex[v]), start, 1'b1});
    if (crlf) begin
      exp_f_q.push_back('{0, 13, start + 10 * BIT, 1'b1});
      exp_f_q.push_back('{0, 10, start + 20 * BIT, 1'b1});
    end
  endfunction

  // Message-level model: a strobe at cycle n starts a message at n+1 if the
  // line is free (n past the last stop cycle), else it replaces the pending value.
  task automatic run_model(input stim_t s[$], input bit crlf);
    int len, end_c, rise, pv;
    bit pend;
    len = crlf ? LEN3 : LEN1;
    end_c = -1; rise = 0; pv = 0; pend = 1'b0;
    exp_f_q.delete(); exp_e_q.delete(); exp_drops = 0;
    foreach (s[i]) begin
      while (end_c >= 0 && s[i].n > end_c) begin
        if (pend) begin push_msg(pv, end_c + 1, crlf); end_c += len; pend = 1'b0; end
        else begin exp_e_q.push_back('{0, rise, end_c + 1}); end_c = -1; end
      end
      if (end_c < 0) begin
        rise = s[i].n + 1;
        push_msg(s[i].v, rise, crlf);
        end_c = s[i].n + len;
      end else begin
        if (pend) exp_drops++;
        pend = 1'b1;
        pv = s[i].v;
      end
    end
    while (end_c >= 0) begin
      if (pend) begin push_msg(pv, end_c + 1, crlf); end_c += len; pend = 1'b0; end
      else begin exp_e_q.push_back('{0, rise, end_c + 1}); end_c = -1; end
    end
  endtask

  task automatic take_line(input int w);
    frame_t rf[$];
    epi_t   re[$];
    got_f.delete(); got_e.delete();
    foreach (act_f_q[i]) if (act_f_q[i].line == w) got_f.push_back(act_f_q[i]); else rf.push_back(act_f_q[i]);
    foreach (act_e_q[i]) if (act_e_q[i].line == w) got_e.push_back(act_e_q[i]); else re.push_back(act_e_q[i]);
    act_f_q = rf;
    act_e_q = re;
  endtask

  task automatic compare_line(input int w, input stim_t s[$], input bit crlf, input string tag);
    run_model(s, crlf);
    take_line(w);
    check({tag, ".frames"}, got_f.size(), exp_f_q.size());
    for (int i = 0; i < got_f.size() && i < exp_f_q.size(); i++) begin
      check($sformatf("%s.byte%0d", tag, i), got_f[i].val, exp_f_q[i].val);
      check($sformatf("%s.start%0d", tag, i), got_f[i].start, exp_f_q[i].start);
      check($sformatf("%s.framing%0d", tag, i), int'(got_f[i].ok), 1);
    end
    check({tag, ".busy_windows"}, got_e.size(), exp_e_q.size());
    for (int i = 0; i < got_e.size() && i < exp_e_q.size(); i++) begin
      check($sformatf("%s.busy_rise%0d", tag, i), got_e[i].rise, exp_e_q[i].rise);
      check($sformatf("%s.busy_len%0d", tag, i), got_e[i].fall - got_e[i].rise,
            exp_e_q[i].fall - exp_e_q[i].rise);
    end
    check({tag, ".drops"}, drop_cnt[w], exp_drops);
    drop_cnt[w] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // Drives a one-cycle strobe on line 0 during cycle n.
  task automatic strobe0_at(input int n, input int v);
    wait_until(n);
    stim0_q.push_back('{cyc, v});
    dv0 = 1'b1;
    data0 = 4'(v);
    tick();
    dv0 = 1'b0;
    data0 = 4'($urandom);
  endtask

  initial begin
    #(10 * 150_000);
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, si, idle_bad, off, n, r, v, n0, e_c;
    rst0 = 1'b1; rst1 = 1'b1; dv0 = 1'b0; dv1 = 1'b0; data0 = '0; data1 = '0;
    drop_cnt[0] = 0; drop_cnt[1] = 0;

    // Reset state
    repeat (5) tick();
    check("reset.txd0", int'(txd0), 1);
    check("reset.busy0", int'(busy0), 0);
    check("reset.dropped0", int'(drop0), 0);
    check("reset.txd1", int'(txd1), 1);
    check("reset.busy1", int'(busy1), 0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Line 0 idles 10000 cycles with junk on data; line 1 runs the no-CRLF traffic meanwhile.
    c0 = cyc;
    stim1_q.push_back('{c0 + 10, 15});
    off = 4500;
    for (int i = 0; i < 4; i++) begin
      off += $urandom_range(1, 1300);
      stim1_q.push_back('{c0 + off, int'($urandom_range(0, 15))});
    end
    si = 0;
    idle_bad = 0;
    for (int i = 0; i < 10000; i++) begin
      dv1 = 1'b0;
      data1 = 4'($urandom);
      data0 = 4'($urandom);
      if (si < stim1_q.size() && stim1_q[si].n == cyc) begin
        dv1 = 1'b1;
        data1 = 4'(stim1_q[si].v);
        si++;
      end
      tick();
      if (txd0 !== 1'b1 || busy0 !== 1'b0 || drop0 !== 1'b0) idle_bad++;
    end
    dv1 = 1'b0;
    check("idle.bad_cycles", idle_bad, 0);
    take_line(0);
    check("idle.frames", got_f.size(), 0);

    // Single 'A' message
    n = cyc + 3;
    strobe0_at(n, 4'hA);
    wait_until(n + LEN3 + 20);
    compare_line(0, stim0_q, 1'b1, "hexA");
    stim0_q.delete();

    // 5, then 7 and 9 while busy: 7 is overwritten
    n = cyc + 3;
    strobe0_at(n, 5);
    strobe0_at(n + 100, 7);
    strobe0_at(n + 200, 9);
    wait_until(n + 2 * LEN3 + 20);
    compare_line(0, stim0_q, 1'b1, "pending");
    stim0_q.delete();

    // Reset during data bit 3 of the first byte
    n = cyc + 3;
    v = $urandom_range(0, 15);
    strobe0_at(n, v);
    stim0_q.delete();
    r = n + 1 + 4 * BIT + 100;
    wait_until(r);
    rst0 = 1'b1;
    tick();
    check("midreset.txd0", int'(txd0), 1);
    check("midreset.busy0", int'(busy0), 0);
    tick();
    tick();
    rst0 = 1'b0;
    tick();
    take_line(0);
    check("midreset.frames", got_f.size(), 0);
    check("midreset.busy_windows", got_e.size(), 1);
    if (got_e.size() > 0) begin
      check("midreset.busy_rise", got_e[0].rise, n + 1);
      check("midreset.busy_fall", got_e[0].fall, r + 1);
    end
    check("midreset.drops", drop_cnt[0], 0);
    drop_cnt[0] = 0;

    // Value 0 after reset, then 3 strobed in the final stop-bit cycle
    n0 = cyc + 3;
    strobe0_at(n0, 0);
    e_c = n0 + LEN3;
    strobe0_at(e_c, 3);
    wait_until(e_c + LEN3 + 20);
    compare_line(0, stim0_q, 1'b1, "stop_edge");
    stim0_q.delete();

    // Line 1 (no CRLF) traffic issued during the idle window
    compare_line(1, stim1_q, 1'b0, "nocrlf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
